// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory responder.
//   dmem_state_e : responder FSM states (IDLE, WAIT, RESP)
//   DMEM_LANES   : byte lanes per data word
//   dmem_req_t   : captured request (we, addr, wdata, be)
// The request struct is sized from DMEM_DATA_W / DMEM_ADDR_W; the responder's
// DataWidth / AddrWidth parameters default to these and must stay equal to them.
package dmem_pkg;

   localparam int DMEM_DATA_W = 32;
   localparam int DMEM_ADDR_W = 32;
   localparam int DMEM_LANES  = DMEM_DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_state_e;

   typedef struct packed {
      logic                   we;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_DATA_W-1:0] wdata;
      logic [DMEM_LANES-1:0]  be;
   } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM, per-byte write enables, registered read.
// Contents and the read register are never reset.
//   clk_i   : clock
//   we_i    : write the byte lanes selected by be_i at idx_i
//   re_i    : load word idx_i into the read register
//   be_i    : byte-lane write enables
//   idx_i   : word index
//   wdata_i : write data
//   rdata_o : read register (updates only on re_i)
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DataWidth = DMEM_DATA_W,
   parameter int Depth     = 1024,
   parameter int IdxW      = 10
) (
   input  logic                   clk_i,
   input  logic                   we_i,
   input  logic                   re_i,
   input  logic [DataWidth/8-1:0] be_i,
   input  logic [IdxW-1:0]        idx_i,
   input  logic [DataWidth-1:0]   wdata_i,
   output logic [DataWidth-1:0]   rdata_o
);

   logic [DataWidth-1:0] r_mem [Depth];
   logic [DataWidth-1:0] r_rdata;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int l = 0; l < DataWidth/8; l++) begin
            if (be_i[l]) r_mem[idx_i][8*l +: 8] <= wdata_i[8*l +: 8];
         end
      end
      if (re_i) r_rdata <= r_mem[idx_i];
   end

   assign rdata_o = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the core's data-memory load/store port.
// Accepts one request (valid/ready), waits WaitStates cycles, commits the
// store or reads the word, then presents a response (valid/ready) that is
// held until taken.
//   clk_i, rst_ni              : clock, synchronous active-low reset
//   req_valid_i / req_ready_o  : request handshake
//   req_we_i, req_addr_i,
//   req_wdata_i, req_be_i      : request payload (byte address, byte enables)
//   rsp_valid_o / rsp_ready_i  : response handshake
//   rsp_rdata_o, rsp_err_o     : load data (0 for stores/errors), fault flag
// Optional feature macro DMEM_RESPONDER_ERR_EN: flag misaligned or
// out-of-range addresses; faulting requests touch nothing and return 0.
// Without it, addr[1:0] is ignored and the word index wraps (Depth is
// expected to be a power of two).
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DataWidth  = DMEM_DATA_W,
   parameter int AddrWidth  = DMEM_ADDR_W,
   parameter int Depth      = 1024,
   parameter int WaitStates = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic                   req_we_i,
   input  logic [AddrWidth-1:0]   req_addr_i,
   input  logic [DataWidth-1:0]   req_wdata_i,
   input  logic [DataWidth/8-1:0] req_be_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [DataWidth-1:0]   rsp_rdata_o,
   output logic                   rsp_err_o
);

   localparam int IdxW   = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int WsLoad = (WaitStates > 0) ? WaitStates - 1 : 0;
   localparam int CntW   = (WsLoad > 0) ? $clog2(WsLoad + 1) : 1;

   dmem_state_e     r_state;
   dmem_req_t       r_req;
   logic [CntW-1:0] r_cnt;
   logic            r_req_ready;
   logic            r_rsp_valid;
   logic            r_rsp_err;
   logic            r_rd_pass;   // response carries array read data

   dmem_req_t            w_in_req;
   dmem_req_t            w_cmt_req;
   logic                 w_accept;
   logic                 w_commit;
   logic                 w_err;
   logic                 w_wr_en;
   logic                 w_rd_en;
   logic [IdxW-1:0]      w_idx;
   logic [DataWidth-1:0] w_arr_rdata;

   assign w_in_req = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i, be: req_be_i};
   assign w_accept = r_req_ready & req_valid_i;

   // With no wait states the commit happens on the accept edge itself, so the
   // array is driven straight from the request inputs instead of the capture.
   assign w_commit  = (WaitStates == 0) ? w_accept
                                        : ((r_state == WAIT) && (r_cnt == '0));
   assign w_cmt_req = (WaitStates == 0) ? w_in_req : r_req;
   assign w_idx     = w_cmt_req.addr[IdxW+1:2];

`ifdef DMEM_RESPONDER_ERR_EN
   assign w_err = (w_cmt_req.addr[1:0] != 2'b00) ||
                  (w_cmt_req.addr[AddrWidth-1:2] >= (AddrWidth-2)'(Depth));
`else
   logic w_unused_addr;
   assign w_err         = 1'b0;
   assign w_unused_addr = ^{w_cmt_req.addr[1:0], w_cmt_req.addr[AddrWidth-1:IdxW+2]};
`endif

   // A reset edge that lands on the commit edge wins: nothing is written.
   assign w_wr_en = w_commit &  w_cmt_req.we & ~w_err & rst_ni;
   assign w_rd_en = w_commit & ~w_cmt_req.we & ~w_err & rst_ni;

   dmem_array #(
      .DataWidth (DataWidth),
      .Depth     (Depth),
      .IdxW      (IdxW)
   ) u_array (
      .clk_i   (clk_i),
      .we_i    (w_wr_en),
      .re_i    (w_rd_en),
      .be_i    (w_cmt_req.be),
      .idx_i   (w_idx),
      .wdata_i (w_cmt_req.wdata),
      .rdata_o (w_arr_rdata)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state     <= IDLE;
         r_req       <= '0;
         r_cnt       <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rd_pass   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_req       <= w_in_req;
                  r_cnt       <= CntW'(WsLoad);
                  r_req_ready <= 1'b0;
                  r_state     <= (WaitStates == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (r_cnt == '0) r_state <= RESP;
               else             r_cnt   <= r_cnt - 1'b1;
            end
            RESP: begin
               // ready rises only after the handshake edge, so a request
               // cannot be taken in the same cycle as the response.
               if (rsp_ready_i) begin
                  r_state     <= IDLE;
                  r_req_ready <= 1'b1;
                  r_rsp_valid <= 1'b0;
                  r_rsp_err   <= 1'b0;
                  r_rd_pass   <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
         if (w_commit) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rd_pass   <= ~w_cmt_req.we & ~w_err;
         end
      end
   end

   // The read register only changes on a load commit, so gating it keeps the
   // data stable through RESP and zero for stores, faults and idle.
   assign rsp_rdata_o = r_rd_pass ? w_arr_rdata : '0;
   assign req_ready_o = r_req_ready;
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: checks two responders side by side, one with
// WaitStates=2 (instance a) and one with WaitStates=0 (instance b).
// Responses are scored against per-instance expectation queues.
module tb_dmem_responder;

`ifdef DMEM_RESPONDER_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        a_rst_n, a_req_valid, a_req_ready, a_we, a_rsp_valid, a_rsp_ready, a_err;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic [3:0]  a_be;
   logic        b_rst_n, b_req_valid, b_req_ready, b_we, b_rsp_valid, b_rsp_ready, b_err;
   logic [31:0] b_addr, b_wdata, b_rdata;
   logic [3:0]  b_be;

   dmem_responder #(.DataWidth(32), .AddrWidth(32), .Depth(1024), .WaitStates(2)) u_a (
      .clk_i(clk), .rst_ni(a_rst_n),
      .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_we),
      .req_addr_i(a_addr), .req_wdata_i(a_wdata), .req_be_i(a_be),
      .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
      .rsp_rdata_o(a_rdata), .rsp_err_o(a_err)
   );

   dmem_responder #(.DataWidth(32), .AddrWidth(32), .Depth(1024), .WaitStates(0)) u_b (
      .clk_i(clk), .rst_ni(b_rst_n),
      .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_we),
      .req_addr_i(b_addr), .req_wdata_i(b_wdata), .req_be_i(b_be),
      .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
      .rsp_rdata_o(b_rdata), .rsp_err_o(b_err)
   );

   rsp_t qa[$];
   rsp_t qb[$];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] be, input logic [31:0] er, input logic ee);
      vec_t v;
      v.we = we; v.addr = a; v.wdata = wd; v.be = be; v.exp_rdata = er; v.exp_err = ee;
      return v;
   endfunction

   // Scoreboard monitors: pop one expectation per response handshake.
   always @(negedge clk) begin : mon_a
      rsp_t e;
      if (a_rst_n && a_rsp_valid && a_rsp_ready) begin
         if (qa.size() == 0) begin
            n_total++;
            $display("FAIL a_unexpected_rsp: got response rdata %h, expected none", a_rdata);
         end else begin
            e = qa.pop_front();
            chk("a_rsp_rdata", a_rdata, e.rdata);
            chk("a_rsp_err", {31'b0, a_err}, {31'b0, e.err});
         end
      end
   end

   always @(negedge clk) begin : mon_b
      rsp_t e;
      if (b_rst_n && b_rsp_valid && b_rsp_ready) begin
         if (qb.size() == 0) begin
            n_total++;
            $display("FAIL b_unexpected_rsp: got response rdata %h, expected none", b_rdata);
         end else begin
            e = qb.pop_front();
            chk("b_rsp_rdata", b_rdata, e.rdata);
            chk("b_rsp_err", {31'b0, b_err}, {31'b0, e.err});
         end
      end
   end

   task automatic set_req(input bit sel, input logic vld, input vec_t v);
      if (sel) begin
         b_req_valid = vld; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata; b_be = v.be;
      end else begin
         a_req_valid = vld; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata; a_be = v.be;
      end
   endtask

   function automatic logic rdy(input bit sel);
      return sel ? b_req_ready : a_req_ready;
   endfunction

   function automatic logic rvld(input bit sel);
      return sel ? b_rsp_valid : a_rsp_valid;
   endfunction

   function automatic void push(input bit sel, input logic [31:0] rd, input logic er);
      rsp_t r;
      r.rdata = rd; r.err = er;
      if (sel) qb.push_back(r); else qa.push_back(r);
   endfunction

   // One full transaction with rsp_ready held high. Entered and left at
   // posedge+1; checks ready around accept and accept-to-valid latency.
   task automatic txn(input bit sel, input vec_t v, input int exp_lat);
      int    lat;
      string p;
      p = sel ? "b" : "a";
      set_req(sel, 1'b1, v);
      push(sel, v.exp_rdata, v.exp_err);
      @(negedge clk);
      chk({p, "_ready_idle"}, {31'b0, rdy(sel)}, 32'd1);
      @(posedge clk); #1;
      set_req(sel, 1'b0, v);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) chk({p, "_ready_busy"}, {31'b0, rdy(sel)}, 32'd0);
      end while (!rvld(sel) && lat < 20);
      chk({p, "_latency"}, lat, exp_lat);
      @(posedge clk); #1;
      @(negedge clk);
      chk({p, "_ready_after"}, {31'b0, rdy(sel)}, 32'd1);
      chk({p, "_valid_after"}, {31'b0, rvld(sel)}, 32'd0);
      @(posedge clk); #1;
   endtask

   vec_t        va[$];
   vec_t        v;
   logic [31:0] bw [4];
   logic [31:0] exp10;
   int          g, t0, t1;

   initial begin
      // Stimulus table for the WaitStates=2 instance
      va.push_back(mk(1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0, 0));
      va.push_back(mk(0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 0));
      va.push_back(mk(1, 32'h20,   32'hAAAAAAAA, 4'hF, 32'h0, 0));
      va.push_back(mk(1, 32'h20,   32'h11223344, 4'h3, 32'h0, 0));
      va.push_back(mk(0, 32'h20,   32'h0,        4'hF, 32'hAAAA3344, 0));
      va.push_back(mk(0, 32'h20,   32'hFFFFFFFF, 4'h0, 32'hAAAA3344, 0));
      va.push_back(mk(1, 32'h24,   32'hCAFEF00D, 4'hF, 32'h0, 0));
      va.push_back(mk(1, 32'h24,   32'h55667788, 4'h0, 32'h0, 0));
      va.push_back(mk(0, 32'h24,   32'h0,        4'hF, 32'hCAFEF00D, 0));
      va.push_back(mk(1, 32'h28,   32'h00000000, 4'hF, 32'h0, 0));
      va.push_back(mk(1, 32'h28,   32'hA1B2C3D4, 4'hA, 32'h0, 0));
      va.push_back(mk(0, 32'h28,   32'h0,        4'hF, 32'hA100C300, 0));
      va.push_back(mk(1, 32'h40,   32'h12345678, 4'hF, 32'h0, 0));
      va.push_back(mk(0, 32'h43,   32'h0,        4'hF, ERR ? 32'h0 : 32'h12345678, ERR));
      va.push_back(mk(1, 32'h13,   32'h0BADF00D, 4'hF, 32'h0, ERR));
      va.push_back(mk(0, 32'h10,   32'h0,        4'hF, ERR ? 32'hDEADBEEF : 32'h0BADF00D, 0));
      va.push_back(mk(1, 32'h0,    32'h77778888, 4'hF, 32'h0, 0));
      va.push_back(mk(0, 32'h1000, 32'h0,        4'hF, ERR ? 32'h0 : 32'h77778888, ERR));
      va.push_back(mk(1, 32'h1000, 32'h99990000, 4'hF, 32'h0, ERR));
      va.push_back(mk(0, 32'h0,    32'h0,        4'hF, ERR ? 32'h77778888 : 32'h99990000, 0));
      exp10 = ERR ? 32'hDEADBEEF : 32'h0BADF00D;
      bw[0] = 32'h01010101; bw[1] = 32'h02020202; bw[2] = 32'h03030303; bw[3] = 32'h04040404;

      v = mk(0, 0, 0, 0, 0, 0);
      set_req(0, 1'b0, v);
      set_req(1, 1'b0, v);
      a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
      a_rst_n = 1'b0; b_rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("a_reset_ready", {31'b0, a_req_ready}, 32'd1);
      chk("a_reset_valid", {31'b0, a_rsp_valid}, 32'd0);
      chk("a_reset_rdata", a_rdata, 32'd0);
      chk("a_reset_err",   {31'b0, a_err}, 32'd0);
      chk("b_reset_ready", {31'b0, b_req_ready}, 32'd1);
      chk("b_reset_valid", {31'b0, b_rsp_valid}, 32'd0);
      @(posedge clk); #1;
      a_rst_n = 1'b1; b_rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (va[i]) txn(0, va[i], 3);

      // Back-pressure: hold the load response for 5 cycles while a store waits.
      txn(0, mk(1, 32'h60, 32'h60606060, 4'hF, 32'h0, 0), 3);
      a_rsp_ready = 1'b0;
      set_req(0, 1'b1, mk(0, 32'h10, 0, 4'hF, 0, 0));
      push(0, exp10, 1'b0);
      @(posedge clk); #1;
      set_req(0, 1'b1, mk(1, 32'h60, 32'hDDDDDDDD, 4'hF, 0, 0));
      push(0, 32'h0, 1'b0);
      g = 0;
      do begin @(negedge clk); g++; end while (!a_rsp_valid && g < 20);
      chk("a_bp_latency", g, 3);
      repeat (5) begin
         chk("a_bp_valid", {31'b0, a_rsp_valid}, 32'd1);
         chk("a_bp_rdata", a_rdata, exp10);
         chk("a_bp_ready", {31'b0, a_req_ready}, 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      a_rsp_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("a_bp_ready_after_hs", {31'b0, a_req_ready}, 32'd1);
      chk("a_bp_valid_after_hs", {31'b0, a_rsp_valid}, 32'd0);
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      @(negedge clk);
      chk("a_bp_store_taken", {31'b0, a_req_ready}, 32'd0);
      g = 0;
      do begin @(negedge clk); g++; end while (!a_rsp_valid && g < 20);
      chk("a_bp_store_latency", g, 2);
      @(posedge clk); #1;
      @(posedge clk); #1;
      txn(0, mk(0, 32'h60, 0, 4'hF, 32'hDDDDDDDD, 0), 3);

      // Reset while a store to 0x30 sits in WAIT.
      txn(0, mk(1, 32'h30, 32'h30303030, 4'hF, 32'h0, 0), 3);
      set_req(0, 1'b1, mk(1, 32'h30, 32'hBAD0BAD0, 4'hF, 0, 0));
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      a_rst_n = 1'b0;
      @(posedge clk); #1;
      a_rst_n = 1'b1;
      @(negedge clk);
      chk("a_rst_mid_ready", {31'b0, a_req_ready}, 32'd1);
      repeat (4) begin
         chk("a_rst_mid_no_rsp", {31'b0, a_rsp_valid}, 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      txn(0, mk(0, 32'h30, 0, 4'hF, 32'h30303030, 0), 3);

      // WaitStates=0: single transactions, then 4 back-to-back loads.
      for (int k = 0; k < 4; k++) txn(1, mk(1, 32'(4*k), bw[k], 4'hF, 32'h0, 0), 1);
      txn(1, mk(1, 32'h4, 32'hFFFF0000, 4'h4, 32'h0, 0), 1);
      bw[1] = 32'h02FF0202;
      t0 = 0;
      set_req(1, 1'b1, mk(0, 32'h0, 0, 4'hF, 0, 0));
      for (int k = 0; k < 4; k++) begin
         g = 0;
         do begin @(negedge clk); g++; end while (!b_req_ready && g < 20);
         chk("b_b2b_accept", {31'b0, b_req_ready}, 32'd1);
         push(1, bw[k], 1'b0);
         @(posedge clk); #1;
         if (k == 0) t0 = cyc;
         if (k < 3) b_addr = 32'(4*(k+1));
         else       b_req_valid = 1'b0;
      end
      g = 0;
      do begin @(negedge clk); g++; end while (!b_rsp_valid && g < 20);
      @(posedge clk); #1;
      t1 = cyc;
      chk("b_b2b_cycles", t1 - t0 + 1, 8);
      @(posedge clk); #1;

      chk("a_queue_drained", qa.size(), 0);
      chk("b_queue_drained", qb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
